// File: rtl/mac_window_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_window_sequencer                                                     |
// | Drives one MAC over N windows of K taps, collects biased window results. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mac_window_sequencer #(
  parameter int INPUT_BIT_RESOLUTION  = 8,
  parameter int OUTPUT_BIT_RESOLUTION = 32,
  parameter int KERNEL_SIZE           = 9,
  parameter int ADDR_W                = 10,
  parameter int WIN_CNT_W             = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [WIN_CNT_W-1:0]             num_windows_i,
  input  logic [ADDR_W-1:0]                fin_base_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] bias_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [ADDR_W-1:0]                fin_addr_o,
  output logic                             fin_rd_o,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  fin_data_i,
  output logic [ADDR_W-1:0]                ker_addr_o,
  output logic                             ker_rd_o,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  ker_data_i,
  output logic                             mac_valid_o,
  output logic [INPUT_BIT_RESOLUTION-1:0]  mac_fin_o,
  output logic [INPUT_BIT_RESOLUTION-1:0]  mac_kernel_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] mac_bias_o,
  input  logic                             mac_valid_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] mac_data_i,
  output logic                             mac_ready_o,
  output logic                             res_valid_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] res_data_o,
  input  logic                             res_ready_i
);

  localparam int                c_TAP_W    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [c_TAP_W-1:0] c_LAST_TAP = c_TAP_W'(KERNEL_SIZE - 1);
  localparam logic [ADDR_W-1:0]  c_K_ADDR   = ADDR_W'(KERNEL_SIZE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_OUT = 3'd1,
    S_LEAD     = 3'd2,
    S_STREAM   = 3'd3,
    S_CLOSE    = 3'd4,
    S_CAPTURE  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [c_TAP_W-1:0]               r_tap;
  logic [WIN_CNT_W-1:0]             r_win;
  logic [WIN_CNT_W-1:0]             r_num;
  logic [ADDR_W-1:0]                r_win_base;
  logic [OUTPUT_BIT_RESOLUTION-1:0] r_bias;
  logic                             r_res_valid;
  logic [OUTPUT_BIT_RESOLUTION-1:0] r_res_data;
  logic                             r_err;

  logic [WIN_CNT_W-1:0]             w_win_inc;
  logic                             w_last_win;
  logic                             w_out_blocked;
  logic                             w_pop;
  logic [ADDR_W-1:0]                w_next_tap;

  assign w_win_inc     = r_win + 1'b1;
  assign w_last_win    = (w_win_inc >= r_num);
  assign w_out_blocked = r_res_valid && !res_ready_i;
  assign w_pop         = r_res_valid && res_ready_i;
  assign w_next_tap    = ADDR_W'(r_tap) + 1'b1;

  assign err_o       = r_err;
  assign mac_bias_o  = r_bias;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    mac_valid_o  = 1'b0;
    mac_ready_o  = 1'b0;
    mac_fin_o    = '0;
    mac_kernel_o = '0;
    fin_rd_o     = 1'b0;
    ker_rd_o     = 1'b0;
    fin_addr_o   = '0;
    ker_addr_o   = '0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_state_nxt = (num_windows_i == '0) ? S_DONE : S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        if (!w_out_blocked) begin
          w_state_nxt = S_LEAD;
        end
      end
      S_LEAD: begin
        // The MAC drops the first pair of each burst, so operands stay zero here.
        mac_valid_o = 1'b1;
        fin_rd_o    = 1'b1;
        ker_rd_o    = 1'b1;
        fin_addr_o  = r_win_base;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        mac_valid_o  = 1'b1;
        mac_fin_o    = fin_data_i;
        mac_kernel_o = ker_data_i;
        if (r_tap == c_LAST_TAP) begin
          w_state_nxt = S_CLOSE;
        end else begin
          fin_rd_o   = 1'b1;
          ker_rd_o   = 1'b1;
          fin_addr_o = r_win_base + w_next_tap;
          ker_addr_o = w_next_tap;
        end
      end
      S_CLOSE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        mac_ready_o = 1'b1;
        w_state_nxt = w_last_win ? S_DONE : S_WAIT_OUT;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tap      <= '0;
      r_win      <= '0;
      r_num      <= '0;
      r_win_base <= '0;
      r_bias     <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_num      <= num_windows_i;
            r_win_base <= fin_base_i;
            r_bias     <= bias_i;
            r_win      <= '0;
            r_err      <= 1'b0;
          end
        end
        S_LEAD: begin
          r_tap <= '0;
        end
        S_STREAM: begin
          if (r_tap != c_LAST_TAP) begin
            r_tap <= r_tap + 1'b1;
          end
        end
        S_CAPTURE: begin
          // A missing result still consumes its window slot.
          r_win      <= w_win_inc;
          r_win_base <= r_win_base + c_K_ADDR;
          if (!mac_valid_i) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // WAIT_OUT only releases once the entry is free or leaving, so capture never overwrites.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if ((r_state == S_CAPTURE) && mac_valid_i) begin
      r_res_valid <= 1'b1;
      r_res_data  <= mac_data_i;
    end else if (w_pop) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_window_sequencer.sv
`default_nettype none
// Bench for mac_window_sequencer: buffer and MAC models plus per-window reference sums.
module tb_mac_window_sequencer;

  localparam int K  = 3;
  localparam int AW = 10;
  localparam int IW = 8;
  localparam int OW = 32;
  localparam int WW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WW-1:0] num;
  logic [AW-1:0] fbase;
  logic [OW-1:0] bias;
  logic          busy, done, err, fin_rd, ker_rd, mac_valid_o, mac_ready_o, res_valid;
  logic [AW-1:0] fin_addr, ker_addr;
  logic [IW-1:0] fin_data, ker_data, mac_fin, mac_ker;
  logic [OW-1:0] mac_bias, res_data, mac_di;
  logic          mac_vi;
  logic          res_ready;

  logic signed [7:0] fin_mem [0:1023];
  logic signed [7:0] ker_mem [0:1023];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int mac_valid_cnt = 0;
  int gate_viol = 0;
  int mac_win_idx = 0;
  int suppress_win = -1;
  int acc = 0;
  bit in_burst = 0;
  bit pend_clear = 0;
  logic [OW-1:0] got_res [$];
  logic [AW-1:0] fin_alog [$];
  logic [AW-1:0] ker_alog [$];
  int lead_cyc [$];
  int cap_cyc [$];

  mac_window_sequencer #(
    .INPUT_BIT_RESOLUTION (IW),
    .OUTPUT_BIT_RESOLUTION(OW),
    .KERNEL_SIZE          (K),
    .ADDR_W               (AW),
    .WIN_CNT_W            (WW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .num_windows_i(num),
    .fin_base_i   (fbase),
    .bias_i       (bias),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .fin_addr_o   (fin_addr),
    .fin_rd_o     (fin_rd),
    .fin_data_i   (fin_data),
    .ker_addr_o   (ker_addr),
    .ker_rd_o     (ker_rd),
    .ker_data_i   (ker_data),
    .mac_valid_o  (mac_valid_o),
    .mac_fin_o    (mac_fin),
    .mac_kernel_o (mac_ker),
    .mac_bias_o   (mac_bias),
    .mac_valid_i  (mac_vi),
    .mac_data_i   (mac_di),
    .mac_ready_o  (mac_ready_o),
    .res_valid_o  (res_valid),
    .res_data_o   (res_data),
    .res_ready_i  (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Synchronous-read buffers, one cycle of latency.
  always @(posedge clk) begin
    if (fin_rd) fin_data <= fin_mem[fin_addr];
    if (ker_rd) ker_data <= ker_mem[ker_addr];
  end

  // Monitor plus MAC model: skip first pair of a burst, offer sum+bias after the burst.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) got_res.push_back(res_data);
      if (done) done_cnt++;
      if (mac_valid_o) mac_valid_cnt++;
      if (fin_rd) fin_alog.push_back(fin_addr);
      if (ker_rd) ker_alog.push_back(ker_addr);
      if (mac_valid_o && !in_burst) begin
        lead_cyc.push_back(cyc);
        if (mac_fin != '0 || mac_ker != '0) gate_viol++;
      end
      if (!mac_valid_o && (mac_fin != '0 || mac_ker != '0)) gate_viol++;
      if (mac_ready_o) cap_cyc.push_back(cyc);
      if (pend_clear) begin
        mac_vi = 1'b0;
        pend_clear = 1'b0;
      end
      if (mac_vi && mac_ready_o) pend_clear = 1'b1;
      if (mac_valid_o) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          acc = 0;
        end else begin
          acc += int'($signed(mac_fin)) * int'($signed(mac_ker));
        end
      end else if (in_burst) begin
        in_burst = 1'b0;
        if (mac_win_idx != suppress_win) begin
          mac_vi = 1'b1;
          mac_di = 32'(acc) + mac_bias;
        end
        mac_win_idx++;
      end
    end else begin
      mac_vi = 1'b0;
      in_burst = 1'b0;
      pend_clear = 1'b0;
      acc = 0;
    end
  end

  function automatic logic [OW-1:0] ref_win(input int b, input int w, input logic [OW-1:0] bs);
    int s;
    s = 0;
    for (int k = 0; k < K; k++) s += int'(fin_mem[(b + w * K + k) % 1024]) * int'(ker_mem[k]);
    return bs + 32'(s);
  endfunction

  task automatic clear_logs();
    got_res.delete();
    fin_alog.delete();
    ker_alog.delete();
    lead_cyc.delete();
    cap_cyc.delete();
  endtask

  task automatic do_start(input logic [WW-1:0] n, input logic [AW-1:0] b, input logic [OW-1:0] bs);
    @(posedge clk); #1;
    num = n; fbase = b; bias = bs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    tests++;
    if ({busy, done, err, fin_rd, ker_rd, mac_valid_o, mac_ready_o, res_valid} !== 8'h00) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000000", {busy, done, err, fin_rd, ker_rd, mac_valid_o, mac_ready_o, res_valid});
    end
    tests++;
    if ({mac_bias, res_data, fin_addr, ker_addr, mac_fin, mac_ker} !== '0) begin
      fails++; $display("FAIL reset_data: got bias %0h res %0h faddr %0h kaddr %0h want all 0", mac_bias, res_data, fin_addr, ker_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    int d0, mv0;
    ker_mem[0] = 8'sd1; ker_mem[1] = 8'sd2; ker_mem[2] = -8'sd1;
    fin_mem[100] = 8'sd3; fin_mem[101] = 8'sd4; fin_mem[102] = -8'sd5;
    clear_logs(); d0 = done_cnt; mv0 = mac_valid_cnt;
    do_start(16'd1, 10'd100, 32'd10);
    wait_done(d0 + 1, 60, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_timeout: got no done want done"); end
    tests++;
    if (got_res.size() != 1) begin fails++; $display("FAIL single_count: got %0d want 1", got_res.size()); end
    else if (got_res[0] !== 32'd26) begin fails++; $display("FAIL single_value: got %0d want 26", got_res[0]); end
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL single_done: got %0d want 1", done_cnt - d0); end
    tests++;
    if (mac_valid_cnt - mv0 != K + 1) begin fails++; $display("FAIL single_mac_cycles: got %0d want %0d", mac_valid_cnt - mv0, K + 1); end
    tests++;
    if (lead_cyc.size() != 1 || cap_cyc.size() != 1) begin
      fails++; $display("FAIL single_period: got %0d/%0d windows want 1", lead_cyc.size(), cap_cyc.size());
    end else if (cap_cyc[0] - lead_cyc[0] + 1 != K + 3) begin
      fails++; $display("FAIL single_period: got %0d want %0d", cap_cyc[0] - lead_cyc[0] + 1, K + 3);
    end
    tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_end_flags: got err %b busy %b want 0 0", err, busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0, b;
    logic [OW-1:0] bs;
    for (int i = 0; i < 1024; i++) begin
      fin_mem[i] = 8'($urandom);
      ker_mem[i] = 8'($urandom);
    end
    b = $urandom_range(1012, 1023);
    bs = $urandom;
    clear_logs(); d0 = done_cnt; gate_viol = 0;
    do_start(16'd4, 10'(b), bs);
    wait_done(d0 + 1, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_timeout: got no done want done"); end
    tests++;
    if (got_res.size() != 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", got_res.size()); end
    else begin
      for (int w = 0; w < 4; w++) begin
        tests++;
        if (got_res[w] !== ref_win(b, w, bs)) begin
          fails++; $display("FAIL b2b_result%0d: got %0h want %0h", w, got_res[w], ref_win(b, w, bs));
        end
      end
    end
    tests++;
    if (fin_alog.size() != 4 * K || ker_alog.size() != 4 * K) begin
      fails++; $display("FAIL b2b_reads: got %0d/%0d want %0d", fin_alog.size(), ker_alog.size(), 4 * K);
    end else begin
      for (int i = 0; i < 4 * K; i++) begin
        tests++;
        if (fin_alog[i] !== 10'(b + i) || ker_alog[i] !== 10'(i % K)) begin
          fails++; $display("FAIL b2b_addr%0d: got %0d/%0d want %0d/%0d", i, fin_alog[i], ker_alog[i], 10'(b + i), i % K);
        end
      end
    end
    tests++;
    if (lead_cyc.size() != 4 || cap_cyc.size() != 4) begin
      fails++; $display("FAIL b2b_timing: got %0d/%0d windows want 4", lead_cyc.size(), cap_cyc.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        if (cap_cyc[w] - lead_cyc[w] + 1 != K + 3) begin
          fails++; $display("FAIL b2b_period%0d: got %0d want %0d", w, cap_cyc[w] - lead_cyc[w] + 1, K + 3);
        end else if (w < 3 && lead_cyc[w + 1] - cap_cyc[w] != 2) begin
          fails++; $display("FAIL b2b_gap%0d: got %0d want 2", w, lead_cyc[w + 1] - cap_cyc[w]);
        end
      end
    end
    tests++;
    if (gate_viol != 0) begin fails++; $display("FAIL b2b_operand_gating: got %0d want 0", gate_viol); end
  endtask

  task automatic test_stall();
    bit ok;
    int d0, mv_snap, b;
    logic [OW-1:0] bs, hold;
    b = $urandom_range(0, 1023);
    bs = $urandom;
    clear_logs(); d0 = done_cnt;
    res_ready = 1'b0;
    do_start(16'd3, 10'(b), bs);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (res_valid) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_first_result: got none want valid"); end
    mv_snap = mac_valid_cnt;
    hold = res_data;
    repeat (20) @(negedge clk);
    tests++;
    if (mac_valid_cnt != mv_snap) begin fails++; $display("FAIL stall_mac_quiet: got %0d want 0 cycles", mac_valid_cnt - mv_snap); end
    tests++;
    if (res_valid !== 1'b1 || res_data !== hold || busy !== 1'b1) begin
      fails++; $display("FAIL stall_hold: got v%b %0h busy %b want v1 %0h busy 1", res_valid, res_data, busy, hold);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_done(d0 + 1, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_timeout: got no done want done"); end
    tests++;
    if (got_res.size() != 3) begin fails++; $display("FAIL stall_count: got %0d want 3", got_res.size()); end
    else begin
      for (int w = 0; w < 3; w++) begin
        if (got_res[w] !== ref_win(b, w, bs)) begin
          fails++; $display("FAIL stall_result%0d: got %0h want %0h", w, got_res[w], ref_win(b, w, bs));
        end
      end
    end
  endtask

  task automatic test_zero();
    int d0, mv0;
    d0 = done_cnt; mv0 = mac_valid_cnt;
    do_start(16'd0, 10'd5, 32'd7);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL zero_done: got done %b busy %b want 1 1", done, busy); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero_after: got done %b busy %b want 0 0", done, busy); end
    repeat (5) @(negedge clk);
    tests++;
    if (mac_valid_cnt != mv0 || done_cnt != d0 + 1) begin
      fails++; $display("FAIL zero_traffic: got mac %0d done %0d want 0 1", mac_valid_cnt - mv0, done_cnt - d0);
    end
  endtask

  task automatic test_error();
    bit ok;
    int d0, b;
    logic [OW-1:0] bs;
    b = $urandom_range(0, 1023);
    bs = $urandom;
    clear_logs(); d0 = done_cnt;
    suppress_win = mac_win_idx + 1;
    do_start(16'd3, 10'(b), bs);
    wait_done(d0 + 1, 200, ok);
    suppress_win = -1;
    tests++;
    if (!ok) begin fails++; $display("FAIL err_timeout: got no done want done"); end
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err); end
    tests++;
    if (got_res.size() != 2) begin fails++; $display("FAIL err_count: got %0d want 2", got_res.size()); end
    else if (got_res[0] !== ref_win(b, 0, bs) || got_res[1] !== ref_win(b, 2, bs)) begin
      fails++; $display("FAIL err_results: got %0h %0h want %0h %0h", got_res[0], got_res[1], ref_win(b, 0, bs), ref_win(b, 2, bs));
    end
    clear_logs(); d0 = done_cnt;
    do_start(16'd1, 10'(b), bs);
    @(negedge clk);
    tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL err_clear: got err %b busy %b want 0 1", err, busy); end
    wait_done(d0 + 1, 100, ok);
    tests++;
    if (!ok || got_res.size() != 1) begin fails++; $display("FAIL err_next_job: got %0d results want 1", got_res.size()); end
    else if (got_res[0] !== ref_win(b, 0, bs)) begin fails++; $display("FAIL err_next_value: got %0h want %0h", got_res[0], ref_win(b, 0, bs)); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0, mv0, l0, b;
    logic [OW-1:0] bs;
    b = $urandom_range(0, 1023);
    bs = $urandom;
    d0 = done_cnt; l0 = lead_cyc.size();
    do_start(16'd3, 10'(b), bs);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (lead_cyc.size() >= l0 + 2) begin ok = 1'b1; break; end
    end
    @(posedge clk); #2;
    tests++;
    if (!ok || mac_valid_o !== 1'b1) begin fails++; $display("FAIL mid_inflight: got mac_valid %b want 1", mac_valid_o); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, err, fin_rd, ker_rd, mac_valid_o, mac_ready_o, res_valid} !== 8'h00) begin
      fails++; $display("FAIL mid_rst_ctrl: got %b want 00000000", {busy, done, err, fin_rd, ker_rd, mac_valid_o, mac_ready_o, res_valid});
    end
    tests++;
    if ({mac_bias, res_data, fin_addr, ker_addr, mac_fin, mac_ker} !== '0) begin
      fails++; $display("FAIL mid_rst_data: got bias %0h res %0h fin %0h want 0", mac_bias, res_data, mac_fin);
    end
    repeat (2) @(posedge clk); #3;
    rst_n = 1'b1;
    tests++;
    if (done_cnt != d0) begin fails++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0); end
    b = $urandom_range(0, 1023);
    bs = $urandom;
    clear_logs(); mv0 = mac_valid_cnt;
    do_start(16'd2, 10'(b), bs);
    repeat (3) @(posedge clk); #1;
    num = 16'd7; fbase = 10'd0; bias = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0 + 1, 100, ok);
    repeat (15) @(negedge clk);
    tests++;
    if (!ok || done_cnt != d0 + 1 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_restart_done: got %0d done busy %b want 1 0", done_cnt - d0, busy);
    end
    tests++;
    if (mac_valid_cnt - mv0 != 2 * (K + 1)) begin fails++; $display("FAIL mid_busy_start: got %0d mac cycles want %0d", mac_valid_cnt - mv0, 2 * (K + 1)); end
    tests++;
    if (got_res.size() != 2) begin fails++; $display("FAIL mid_restart_count: got %0d want 2", got_res.size()); end
    else if (got_res[0] !== ref_win(b, 0, bs) || got_res[1] !== ref_win(b, 1, bs)) begin
      fails++; $display("FAIL mid_restart_values: got %0h %0h want %0h %0h", got_res[0], got_res[1], ref_win(b, 0, bs), ref_win(b, 1, bs));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num = '0; fbase = '0; bias = '0;
    res_ready = 1'b1; mac_vi = 1'b0; mac_di = '0; fin_data = '0; ker_data = '0;
    for (int i = 0; i < 1024; i++) begin
      fin_mem[i] = 8'($urandom);
      ker_mem[i] = 8'($urandom);
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
